// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The baud helper lets a top level derive its bit period from clock and baud rate.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam int CLK_72MHZ_HZ = 72_000_000;

  // Rounded to the nearest whole clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered full/empty/level flags.
// The read port shows the head word combinationally; rd_en pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             push, pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign wr_nxt  = wr_ptr + (AW+1)'(push);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Flags are computed from the next pointers so they stay registered yet current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      level  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
      level  <= wr_nxt - rd_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame engine with configurable data width,
// parity and stop bits; queued words leave back-to-back with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = clks_per_bit(CLK_72MHZ_HZ, 115200),
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PARITY_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_q;

  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd;
  logic                 bit_end, pop, par_calc;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_valid),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end  = (timer == T_LAST);
  assign par_calc = (PARITY == PARITY_ODD) ? ~(^fifo_rd) : (^fifo_rd);
  // Pop either from idle or on the very last stop cycle, so the next start bit follows directly.
  assign pop      = !fifo_empty &&
                    ((state == S_IDLE) || (state == S_STOP && bit_end && bit_cnt == STOP_LAST));
  assign wr_ready = !fifo_full;
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_q     <= 1'b0;
      serial_tx <= 1'b1;
    end else begin
      if (state == S_IDLE || bit_end) timer <= '0;
      else                            timer <= timer + TW'(1);

      case (state)
        S_IDLE: begin
          if (pop) begin
            shift     <= fifo_rd;
            par_q     <= par_calc;
            serial_tx <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            serial_tx <= shift[0];
            shift     <= shift >> 1;
            bit_cnt   <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                serial_tx <= par_q;
                state     <= S_PARITY;
              end else begin
                serial_tx <= 1'b1;
                state     <= S_STOP;
              end
            end else begin
              serial_tx <= shift[0];
              shift     <= shift >> 1;
              bit_cnt   <= bit_cnt + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            serial_tx <= 1'b1;
            bit_cnt   <= '0;
            state     <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shift     <= fifo_rd;
                par_q     <= par_calc;
                serial_tx <= 1'b0;
                state     <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: begin
          serial_tx <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
